// File: rtl/vcd_change_logger_if.sv
// Record stream interface of vcd_change_logger: show-ahead head record
// (time, value) with a valid/ready handshake toward the dump consumer.
interface vcd_change_logger_if #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16
);
    logic                rec_valid;
    logic                rec_ready;
    logic [TS_WIDTH-1:0] rec_time;
    logic [WIDTH-1:0]    rec_value;

    modport master (
        output rec_valid,
        output rec_time,
        output rec_value,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_time,
        input  rec_value,
        output rec_ready
    );
endinterface

// File: rtl/vcd_change_logger.sv
// vcd_change_logger: watches one data word and queues a timestamped record
// for the initial snapshot after enable rises and for every later change.
// Records sit in a show-ahead FIFO drained through the rec stream interface.
// Optional build macro VCD_LOGGER_WRAP_RECORD_EN: when defined, the edge on
// which the timestamp wraps to zero also forces a record (ts = all ones) so
// the reader can count timestamp epochs.
module vcd_change_logger #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       data_in,
    vcd_change_logger_if.master    rec,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]       LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]       LVL_ONE  = LW'(1);
    localparam logic [AW-1:0]       PTR_ONE  = AW'(1);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic                armed_q, armed_d;
    logic                overflow_q, overflow_d;
    logic [LW-1:0]       level_q, level_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [TS_WIDTH-1:0] mem_time_q  [DEPTH];
    logic [WIDTH-1:0]    mem_value_q [DEPTH];

    logic wrap_s;
    logic push_s;
    logic pop_s;
    logic full_s;
    logic wr_s;
    logic drop_s;

`ifdef VCD_LOGGER_WRAP_RECORD_EN
    // The edge that takes ts from all ones back to zero forces a record.
    assign wrap_s = (ts_q == {TS_WIDTH{1'b1}});
`else
    // Wraps are left for the consumer to infer from decreasing timestamps.
    assign wrap_s = 1'b0;
`endif

    // Record generation and FIFO handshake decode.
    always_comb begin
        push_s = 1'b0;
        if (enable) begin
            push_s = (!armed_q) || (data_in != prev_q) || wrap_s;
        end else begin
            push_s = 1'b0;
        end
        pop_s  = (level_q != {LW{1'b0}}) && rec.rec_ready;
        full_s = (level_q == LVL_FULL);
        // A push into a full FIFO only fits when the head leaves on the same edge.
        wr_s   = push_s && ((!full_s) || pop_s);
        drop_s = push_s && full_s && (!pop_s);
    end

    // Next-state for timestamp, change detector, pointers, level and sticky flag.
    always_comb begin
        ts_d       = ts_q;
        prev_d     = data_in;
        armed_d    = enable;
        overflow_d = overflow_q | drop_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (enable) begin
            ts_d = ts_q + TS_ONE;
        end else begin
            ts_d = ts_q;
        end
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (pop_s && !wr_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Control state registers; reset discards every buffered record at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q       <= {TS_WIDTH{1'b0}};
            prev_q     <= {WIDTH{1'b0}};
            armed_q    <= 1'b0;
            overflow_q <= 1'b0;
            level_q    <= {LW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            armed_q    <= armed_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Record storage; cleared on reset so the idle head reads as (0, 0).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_time_q[i]  <= {TS_WIDTH{1'b0}};
                mem_value_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_s) begin
            mem_time_q[wr_ptr_q]  <= ts_q;
            mem_value_q[wr_ptr_q] <= data_in;
        end else begin
            mem_time_q[wr_ptr_q]  <= mem_time_q[wr_ptr_q];
            mem_value_q[wr_ptr_q] <= mem_value_q[wr_ptr_q];
        end
    end

    // Show-ahead head; valid comes from the stored level only, never from ready.
    assign rec.rec_valid = (level_q != {LW{1'b0}});
    assign rec.rec_time  = mem_time_q[rd_ptr_q];
    assign rec.rec_value = mem_value_q[rd_ptr_q];
    assign overflow      = overflow_q;
    assign level         = level_q;

endmodule
